io_bank: RTL and testbench



---
 rtl/io_bank.sv | 155 +++++++++++++++
 tb/tb_io_bank.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bank.sv
// io_bank: WIDTH-bit bidirectional pad bank with per-bit drive modes and a synchronised,
// glitch-filtered input path. Optional rising-edge pulses: define IO_BANK_EDGE_DETECT_EN.
module io_bank #(
  parameter int WIDTH      = 8,
  parameter int FILTER_LEN = 3,
  parameter int ADDR_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  inout  wire  [WIDTH-1:0]  pad,
  input  logic [WIDTH-1:0]  f2p,
  output logic [WIDTH-1:0]  p2f,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [1:0]        cfg_mode,
  output logic [1:0]        cfg_rmode,
  output logic [WIDTH-1:0]  p2f_rise
);

  localparam logic [1:0] MODE_IN  = 2'b00;
  localparam logic [1:0] MODE_PP  = 2'b01;
  localparam logic [1:0] MODE_OD  = 2'b10;
  localparam logic [1:0] MODE_REG = 2'b11;

  logic [WIDTH-1:0][1:0] mode_r;
  logic [WIDTH-1:0]      f2p_q_r;
  logic [WIDTH-1:0]      s1_r;
  logic [WIDTH-1:0]      s2_r;
  logic [WIDTH-1:0]      p2f_r;
  logic [WIDTH-1:0]      oe_s;
  logic [WIDTH-1:0]      dout_s;
  logic [1:0]            rmode_s;

  // Returns {output enable, driven value} for one bit.
  function automatic logic [1:0] pad_drive(input logic [1:0] mode, input logic f,
                                           input logic fq);
    logic [1:0] res;
    case (mode)
      MODE_IN:  res = 2'b00;
      MODE_PP:  res = {1'b1, f};
      MODE_OD:  res = {~f, 1'b0};
      MODE_REG: res = {1'b1, fq};
      default:  res = 2'b00;
    endcase
    return res;
  endfunction

  // Mode registers; addresses at or beyond WIDTH match no bit and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (cfg_we && (cfg_addr == ADDR_W'(i))) begin
          mode_r[i] <= cfg_mode;
        end
      end
    end
  end

  // Combinational mode readback, zero for out-of-range addresses.
  always_comb begin
    rmode_s = 2'b00;
    for (int i = 0; i < WIDTH; i++) begin
      rmode_s = (cfg_addr == ADDR_W'(i)) ? mode_r[i] : rmode_s;
    end
  end

  assign cfg_rmode = rmode_s;

  // Pad driver decode per bit.
  always_comb begin
    oe_s   = '0;
    dout_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {oe_s[i], dout_s[i]} = pad_drive(mode_r[i], f2p[i], f2p_q_r[i]);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_pad
    assign pad[g] = oe_s[g] ? dout_s[g] : 1'bz;
  end

  // Registered-mode output flops and the two-stage input synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f2p_q_r <= '0;
      s1_r    <= '0;
      s2_r    <= '0;
    end else begin
      f2p_q_r <= f2p;
      s1_r    <= pad;
      s2_r    <= s1_r;
    end
  end

  generate
    if (FILTER_LEN > 0) begin : g_filt
      localparam int CW = $clog2(FILTER_LEN + 1);
      localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);
      logic [WIDTH-1:0][CW-1:0] cnt_r;

      // p2f follows s2 only after FILTER_LEN consecutive differing cycles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_r <= '0;
          p2f_r <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (s2_r[i] == p2f_r[i]) begin
              cnt_r[i] <= '0;
            end else if (cnt_r[i] == LAST) begin
              p2f_r[i] <= s2_r[i];
              cnt_r[i] <= '0;
            end else begin
              cnt_r[i] <= cnt_r[i] + CW'(1);
            end
          end
        end
      end
    end else begin : g_nofilt
      // Filter bypassed: one register stage after the synchroniser.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p2f_r <= '0;
        end else begin
          p2f_r <= s2_r;
        end
      end
    end
  endgenerate

  assign p2f = p2f_r;

`ifdef IO_BANK_EDGE_DETECT_EN
  logic [WIDTH-1:0] p2f_d_r;
  logic [WIDTH-1:0] rise_r;

  // Registered rising-edge detect: pulse lands one cycle after p2f rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2f_d_r <= '0;
      rise_r  <= '0;
    end else begin
      p2f_d_r <= p2f_r;
      rise_r  <= p2f_r & ~p2f_d_r;
    end
  end

  assign p2f_rise = rise_r;
`else
  assign p2f_rise = '0;
`endif

endmodule

// File: tb/tb_io_bank.sv
// Self-checking bench for io_bank: window-based model of sync+filter checked every cycle,
// plus directed literal checks; a WIDTH=6 instance covers out-of-range config writes.
module tb_io_bank;
  localparam int N = 3;
`ifdef IO_BANK_EDGE_DETECT_EN
  localparam logic EDGE_EN = 1'b1;
`else
  localparam logic EDGE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] f2p = 8'h00;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = 3'd0;
  logic [1:0] cfg_mode = 2'b00;
  logic [7:0] ext_en = 8'hFF;
  logic [7:0] ext_val = 8'h00;
  wire  [7:0] pad;
  logic [7:0] p2f;
  logic [1:0] cfg_rmode;
  logic [7:0] p2f_rise;

  logic [5:0] f2p6 = 6'h00;
  logic       cfg6_we = 1'b0;
  logic [2:0] cfg6_addr = 3'd0;
  logic [1:0] cfg6_mode = 2'b00;
  wire  [5:0] pad6;
  logic [5:0] p2f6;
  logic [1:0] cfg6_rmode;
  logic [5:0] p2f6_rise;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 8; i++) begin : g_ext
    assign pad[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end
  for (genvar i = 0; i < 6; i++) begin : g_ext6
    assign pad6[i] = 1'b0;
  end

  io_bank #(.WIDTH(8), .FILTER_LEN(N), .ADDR_W(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .pad(pad), .f2p(f2p), .p2f(p2f),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode),
    .cfg_rmode(cfg_rmode), .p2f_rise(p2f_rise)
  );

  io_bank #(.WIDTH(6), .FILTER_LEN(N), .ADDR_W(3)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .pad(pad6), .f2p(f2p6), .p2f(p2f6),
    .cfg_we(cfg6_we), .cfg_addr(cfg6_addr), .cfg_mode(cfg6_mode),
    .cfg_rmode(cfg6_rmode), .p2f_rise(p2f6_rise)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state after the most recent clock edge.
  logic [1:0] m_mode [8];
  logic [7:0] m_fq, m_p2f, m_p2f_old, m_rise;
  logic [7:0] hist [$];

  task automatic mdl_reset();
    for (int i = 0; i < 8; i++) m_mode[i] = 2'b00;
    m_fq = 8'h00; m_p2f = 8'h00; m_p2f_old = 8'h00; m_rise = 8'h00;
    hist.delete();
    for (int i = 0; i < N + 2; i++) hist.push_back(8'h00);
  endtask

  // Per-cycle compare at negedge, then advance the model to the next posedge.
  always @(negedge clk) begin
    logic [7:0] ep, known, nrise;
    logic       all_diff;
    if (!rst_n) begin
      mdl_reset();
      chk("m_rst_p2f", p2f, 8'h00);
      chk("m_rst_rise", p2f_rise, 8'h00);
    end else begin
      ep = 8'h00; known = 8'h00;
      for (int i = 0; i < 8; i++) begin
        if (m_mode[i] == 2'b01) begin
          ep[i] = f2p[i]; known[i] = 1'b1;
        end else if (m_mode[i] == 2'b11) begin
          ep[i] = m_fq[i]; known[i] = 1'b1;
        end else if (m_mode[i] == 2'b10 && f2p[i] == 1'b0) begin
          ep[i] = 1'b0; known[i] = 1'b1;
        end else if (ext_en[i]) begin
          ep[i] = ext_val[i]; known[i] = 1'b1;
        end else begin
          ep[i] = 1'b0;
        end
      end
      chk("m_pad", pad & known, ep & known);
      chk("m_p2f", p2f, m_p2f);
      chk("m_rise", p2f_rise, m_rise);
      chk("m_rmode", cfg_rmode, m_mode[cfg_addr]);
      // The filter sees the pad sample from two edges earlier; p2f flips once the
      // last N seen samples all disagree with it.
      hist.push_back(ep);
      void'(hist.pop_front());
      if (cfg_we) m_mode[cfg_addr] = cfg_mode;
      m_fq = f2p;
      nrise = m_p2f & ~m_p2f_old;
      m_p2f_old = m_p2f;
      for (int b = 0; b < 8; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < N; j++) begin
          if (hist[hist.size() - 3 - j][b] == m_p2f[b]) all_diff = 1'b0;
        end
        if (all_diff) m_p2f[b] = ~m_p2f[b];
      end
      m_rise = EDGE_EN ? nrise : 8'h00;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    step(2);

    // Externally driven pattern reaches p2f exactly 2+N edges later.
    ext_val = 8'hA5;
    step(4);
    chk("p2f_before_5", p2f, 8'h00);
    step(1);
    chk("p2f_at_5", p2f, 8'hA5);
    chk("pad_input", pad, 8'hA5);
    for (int a = 0; a < 8; a++) begin
      cfg_addr = 3'(a);
      #1;
      chk("rmode_reset", cfg_rmode, 2'b00);
    end
    step(1);

    // Narrow bank: out-of-range writes are ignored and read back as zero.
    cfg6_we = 1'b1; cfg6_addr = 3'd7; cfg6_mode = 2'b01;
    step(1);
    cfg6_addr = 3'd6; cfg6_mode = 2'b11;
    step(1);
    cfg6_we = 1'b0;
    for (int a = 0; a < 8; a++) begin
      cfg6_addr = 3'(a);
      #1;
      chk("rmode6_oor", cfg6_rmode, 2'b00);
    end
    step(1);
    cfg6_we = 1'b1; cfg6_addr = 3'd5; cfg6_mode = 2'b11;
    step(1);
    cfg6_we = 1'b0;
    #1;
    chk("rmode6_top", cfg6_rmode, 2'b11);

    // Push-pull then open-drain on bit 3.
    cfg_we = 1'b1; cfg_addr = 3'd3; cfg_mode = 2'b01; f2p = 8'h08;
    step(1);
    cfg_we = 1'b0; ext_en[3] = 1'b0;
    #1;
    chk("pp_pad", pad, 8'hAD);
    chk("pp_rmode", cfg_rmode, 2'b01);
    step(6);
    chk("pp_loopback", p2f, 8'hAD);
    cfg_we = 1'b1; cfg_mode = 2'b10;
    step(1);
    cfg_we = 1'b0; ext_en[3] = 1'b1; ext_val[3] = 1'b0;
    #1;
    chk("od_hiz", pad, 8'hA5);
    step(1);
    f2p[3] = 1'b0; ext_en[3] = 1'b0;
    #1;
    chk("od_low", pad, 8'hA5);

    // Registered mode on bit 0.
    ext_val[0] = 1'b0; f2p[0] = 1'b0;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_mode = 2'b11;
    step(1);
    cfg_we = 1'b0; ext_en[0] = 1'b0;
    step(7);
    f2p[0] = 1'b1;
    #1;
    chk("reg_hold", pad[0], 1'b0);
    step(1);
    chk("reg_pad", pad, 8'hA5);
    step(4);
    chk("reg_p2f_early", p2f[0], 1'b0);
    step(1);
    chk("reg_p2f", p2f[0], 1'b1);

    // Glitch rejection on bit 5.
    ext_val[5] = 1'b0;
    step(8);
    chk("glitch_base", p2f[5], 1'b0);
    ext_val[5] = 1'b1;
    step(2);
    ext_val[5] = 1'b0;
    step(8);
    chk("glitch_reject", p2f[5], 1'b0);
    ext_val[5] = 1'b1;
    step(3);
    ext_val[5] = 1'b0;
    step(1);
    chk("pulse3_early", p2f[5], 1'b0);
    step(1);
    chk("pulse3_accept", p2f[5], 1'b1);
    step(8);

    // Rising edge pulse on bit 2; falling edge gives none.
    ext_val[2] = 1'b0;
    step(8);
    ext_val[2] = 1'b1;
    step(5);
    chk("edge_p2f", p2f[2], 1'b1);
    chk("edge_rise_pre", p2f_rise[2], 1'b0);
    step(1);
    chk("edge_rise", p2f_rise[2], EDGE_EN);
    step(1);
    chk("edge_rise_post", p2f_rise[2], 1'b0);
    ext_val[2] = 1'b0;
    step(8);
    chk("edge_fall", p2f_rise, 8'h00);

    // Asynchronous reset in the middle of a filter count.
    ext_val[6] = 1'b1;
    step(3);
    rst_n = 1'b0; ext_en = 8'hFF; ext_val[0] = 1'b0; ext_val[3] = 1'b0;
    #1;
    chk("rst_p2f", p2f, 8'h00);
    chk("rst_pad", pad, ext_val);
    chk("rst_rmode", cfg_rmode, 2'b00);
    step(2);
    rst_n = 1'b1;
    step(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
